fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter QUEUE_DEPTH, default 2, instruction queue entries (legal 2..4).
REQ-002 Parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory, valid this cycle.
REQ-006 imem_addr  output  8  fetch address; meaningful only while imem_req=1.
REQ-007 imem_rvalid  input  1  response for the oldest outstanding request; responses return in order, one or more cycles after request.
REQ-008 imem_rdata  input  8  instruction byte; valid while imem_rvalid=1.
REQ-009 redirect_valid  input  1  branch/jump redirect from a later stage.
REQ-010 redirect_pc  input  8  new fetch PC; valid while redirect_valid=1.
REQ-011 if_valid  output  1  queue head holds a valid instruction for the IF/ID register.
REQ-012 id_ready  input  1  downstream accepts the head this cycle.
REQ-013 Instruction_Code_IF  output  8  instruction byte at queue head.
REQ-014 PC_IF  output  8  PC of instruction at queue head.
REQ-015 halted  output  1  fetch stopped on halt opcode.

Function
REQ-016 States: FETCH, HALT; at most one memory request outstanding at any time.
REQ-017 imem_req=1 iff state=FETCH, redirect_valid=0, no request outstanding (or imem_rvalid=1 this cycle for the outstanding one), and queue count + outstanding < QUEUE_DEPTH; imem_addr=PC.
REQ-018 On an issued request, PC <= PC+1 modulo 256 (8'hFF wraps to 8'h00); issuing PC is recorded with the request.
REQ-019 On imem_rvalid=1 with no drop pending, {recorded PC, imem_rdata} is pushed to the queue tail.
REQ-020 if_valid = queue not empty; Instruction_Code_IF/PC_IF driven from head storage flops; head popped when if_valid & id_ready.
REQ-021 Push and pop in the same cycle are both performed; push never targets a full queue, as space is reserved at request issue.
REQ-022 Minimum latency: request at cycle N, rvalid at N+1 -> if_valid at N+2.
REQ-023 Redirect has highest priority: queue flushed, PC <= redirect_pc, state <= FETCH, halted <= 0, no request issued that cycle; a pop in the same cycle is discarded.
REQ-024 Redirect with a request outstanding and no imem_rvalid that cycle sets a drop flag; the next response is discarded and clears the flag.
REQ-025 Redirect coincident with imem_rvalid discards that response; drop flag not set.
REQ-026 Outputs Instruction_Code_IF/PC_IF read 8'h00 whenever if_valid=0.

Reset
REQ-027 While reset=1: PC=RESET_PC, queue empty, outstanding=0, drop flag=0, state=FETCH, imem_req=0, if_valid=0, halted=0, Instruction_Code_IF=PC_IF=8'h00.
REQ-028 Reset asserted mid-transaction abandons the outstanding request; any imem_rvalid during or after reset is ignored until a new request is issued.
REQ-029 First imem_req asserts in the first cycle with reset=0.

Configuration
REQ-030 Macro FETCH_HALT_DETECT_EN: when defined, pushing imem_rdata=8'hFF sets state=HALT and halted=1; no further requests; the queue still drains; exit only by redirect or reset.
REQ-031 Without FETCH_HALT_DETECT_EN, 8'hFF is an ordinary instruction, HALT state is unused, and halted is tied 0.

Structure
REQ-032 Shared package fetch_pkg holds: instruction and PC width constants (8), HALT_OPCODE (8'hFF), and the fetch state enum.
REQ-033 Queue is a separate sub-module fetch_queue (synchronous FIFO with push, pop, flush, count, and {pc,instr} entries).

Verification
REQ-034 Reset, 1-cycle memory, id_ready=1 -> PC_IF sequence 00,01,02,... with if_valid high every cycle after cycle 2.
REQ-035 id_ready=0 for 6 cycles -> queue fills to QUEUE_DEPTH, imem_req drops to 0, no entry lost, order preserved on release.
REQ-036 redirect_pc=8'h40 while a request is outstanding and the response arrives 2 cycles later -> response dropped, next PC_IF=8'h40.
REQ-037 RESET_PC=8'hFE -> PC_IF sequence FE,FF,00,01 (wrap).
REQ-038 FETCH_HALT_DETECT_EN defined, memory returns 8'hFF at PC 8'h03 -> halted=1, no imem_req after it, queue drains; redirect to 8'h10 resumes fetch.
REQ-039 Reset asserted with a request outstanding, stale rvalid arrives 1 cycle after release -> ignored; first PC_IF=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned PC_W    = 8;

    localparam logic [INSTR_W-1:0] HALT_OPCODE = 8'hFF;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

    // One queued instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous instruction FIFO with flush; head reads as zero when empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    output logic                         head_valid,
    output fetch_entry_t                 head_entry,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next pointer/count/storage; flush wins over push and pop.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_valid = (count_q != '0);
    assign head_entry = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory requests feeding a small queue
// toward IF/ID, with redirect flush and stale-response dropping.
// Optional halt-opcode detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     QUEUE_DEPTH = 2,
    parameter logic [PC_W-1:0] RESET_PC    = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] Instruction_Code_IF,
    output logic [PC_W-1:0]    PC_IF,
    output logic               halted
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            out_q, out_d;
    logic            drop_q, drop_d;
    logic            halted_q, halted_d;

    logic             req_c, rsp_c, push_c, pop_c;
    logic [OCC_W-1:0] occ_c;
    logic             q_valid;
    fetch_entry_t     q_head;
    logic [CNT_W-1:0] q_count;

    // Issue, response, redirect and halt control.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        out_d    = out_q;
        drop_d   = drop_q;
        halted_d = halted_q;

        rsp_c  = imem_rvalid && out_q;
        pop_c  = q_valid && id_ready && !redirect_valid;
        push_c = rsp_c && !drop_q && !redirect_valid && (state_q == FETCH);
        // Slots already reserved; a pop this cycle frees one for the next fetch.
        occ_c  = OCC_W'(q_count) + OCC_W'(out_q) - OCC_W'(pop_c);
        req_c  = !reset && (state_q == FETCH) && !redirect_valid &&
                 (!out_q || imem_rvalid) && (occ_c < OCC_W'(QUEUE_DEPTH));

        if (rsp_c) begin
            out_d  = 1'b0;
            drop_d = 1'b0;
        end
        if (req_c) begin
            out_d    = 1'b1;
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_W'(1);
        end
`ifdef FETCH_HALT_DETECT_EN
        if (push_c && (imem_rdata == HALT_OPCODE)) begin
            state_d  = HALT;
            halted_d = 1'b1;
        end
`endif
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            state_d  = FETCH;
            halted_d = 1'b0;
            drop_d   = out_q && !imem_rvalid;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            out_q    <= 1'b0;
            drop_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            halted_q <= halted_d;
        end
    end

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push_c),
        .push_entry ('{pc: req_pc_q, instr: imem_rdata}),
        .pop        (pop_c),
        .head_valid (q_valid),
        .head_entry (q_head),
        .count      (q_count)
    );

    assign imem_req            = req_c;
    assign imem_addr           = pc_q;
    assign if_valid            = q_valid;
    assign Instruction_Code_IF = q_head.instr;
    assign PC_IF               = q_head.pc;
    assign halted              = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table plus an in-order scoreboard.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       id_ready = 1'b0;
    logic       imem_req, imem_rvalid, if_valid, halted;
    logic [7:0] imem_addr, imem_rdata, Instruction_Code_IF, PC_IF;

    logic       req_fe, valid_fe, halted_fe;
    logic [7:0] addr_fe, instr_fe, pc_fe;
    logic       rv_fe = 1'b0;
    logic [7:0] a_fe = 8'h00;

    fetch_unit #(.QUEUE_DEPTH(2), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .id_ready(id_ready),
        .Instruction_Code_IF(Instruction_Code_IF), .PC_IF(PC_IF), .halted(halted)
    );

    fetch_unit #(.QUEUE_DEPTH(2), .RESET_PC(8'hFE)) dut_fe (
        .clk(clk), .reset(reset), .imem_req(req_fe), .imem_addr(addr_fe),
        .imem_rvalid(rv_fe), .imem_rdata(a_fe ^ 8'h5A),
        .redirect_valid(1'b0), .redirect_pc(8'h00),
        .if_valid(valid_fe), .id_ready(1'b1),
        .Instruction_Code_IF(instr_fe), .PC_IF(pc_fe), .halted(halted_fe)
    );

    // Fixed one-cycle memory for the wrap instance.
    always @(posedge clk) begin
        rv_fe <= req_fe && !reset;
        a_fe  <= addr_fe;
    end

    // Main memory model: one request in flight, configurable latency.
    int         mem_lat = 1;
    logic       ff_at3 = 1'b0;
    logic       stale_rv = 1'b0;
    logic [7:0] stale_data = 8'h00;
    logic       pend = 1'b0;
    int         pend_cnt = 0;
    logic [7:0] pend_addr = 8'h00;
    logic       model_rv;

    assign model_rv    = pend && (pend_cnt == 1);
    assign imem_rvalid = model_rv || stale_rv;
    assign imem_rdata  = stale_rv ? stale_data :
                         !model_rv ? 8'h00 :
                         (ff_at3 && pend_addr == 8'h03) ? 8'hFF : (pend_addr ^ 8'h5A);

    always @(posedge clk) begin
        if (reset) begin
            pend <= 1'b0;
        end else if (imem_req) begin
            pend      <= 1'b1;
            pend_cnt  <= mem_lat;
            pend_addr <= imem_addr;
        end else if (model_rv) begin
            pend <= 1'b0;
        end else if (pend) begin
            pend_cnt <= pend_cnt - 1;
        end
    end

    typedef struct { logic [7:0] pc; logic [7:0] instr; } exp_t;
    typedef struct { logic rdy; logic v; logic [7:0] pc; logic req; logic [7:0] addr; } vec_t;

    exp_t exp_q[$];
    vec_t tbl[16];
    int   errors = 0;
    int   checks = 0;
    int   sb_pops = 0;

    function automatic logic [7:0] instr_of(input logic [7:0] a);
        return (ff_at3 && a == 8'h03) ? 8'hFF : (a ^ 8'h5A);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected fetch stream starting at pc, queued when reset/redirect is driven.
    task automatic sb_reload(input logic [7:0] pc);
        exp_t e;
        exp_q.delete();
        sb_pops = 0;
        for (int i = 0; i < 48; i++) begin
            e.pc    = pc + 8'(i);
            e.instr = instr_of(e.pc);
            exp_q.push_back(e);
        end
    endtask

    // One clock: compare any accepted head against the scoreboard at negedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (if_valid && id_ready && !redirect_valid) begin
            sb_pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got pc %02h expected no entry", PC_IF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", PC_IF, e.pc);
                chk("sb_instr", Instruction_Code_IF, e.instr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!if_valid && n < budget) begin
            step();
            n++;
        end
        chk(name, 8'(if_valid), 8'h01);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] e;
        // Cycle 0 is the first cycle with reset low; depth 2, 1-cycle memory.
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01};
        tbl[2]  = '{1'b1, 1'b1, 8'h00, 1'b1, 8'h02};
        tbl[3]  = '{1'b1, 1'b1, 8'h01, 1'b1, 8'h03};
        tbl[4]  = '{1'b1, 1'b1, 8'h02, 1'b1, 8'h04};
        tbl[5]  = '{1'b0, 1'b1, 8'h03, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 1'b1, 8'h03, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 1'b1, 8'h03, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 1'b1, 8'h03, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 1'b1, 8'h03, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 1'b1, 8'h03, 1'b0, 8'h00};
        tbl[11] = '{1'b1, 1'b1, 8'h03, 1'b1, 8'h05};
        tbl[12] = '{1'b1, 1'b1, 8'h04, 1'b1, 8'h06};
        tbl[13] = '{1'b1, 1'b1, 8'h05, 1'b1, 8'h07};
        tbl[14] = '{1'b1, 1'b1, 8'h06, 1'b1, 8'h08};
        tbl[15] = '{1'b1, 1'b1, 8'h07, 1'b1, 8'h09};

        // Reset state
        @(posedge clk);
        #1;
        do_reset();
        chk("rst if_valid", 8'(if_valid), 8'h00);
        chk("rst pc_if", PC_IF, 8'h00);
        chk("rst instr", Instruction_Code_IF, 8'h00);
        chk("rst imem_req", 8'(imem_req), 8'h00);
        chk("rst halted", 8'(halted), 8'h00);
        chk("rst fe pc_if", pc_fe, 8'h00);

        // Streaming, back-pressure fill and release, plus PC wrap instance
        sb_reload(8'h00);
        reset = 1'b0;
        for (int c = 0; c < 16; c++) begin
            id_ready = tbl[c].rdy;
            #1;
            chk($sformatf("c%0d if_valid", c), 8'(if_valid), 8'(tbl[c].v));
            chk($sformatf("c%0d pc_if", c), PC_IF, tbl[c].v ? tbl[c].pc : 8'h00);
            chk($sformatf("c%0d instr", c), Instruction_Code_IF,
                tbl[c].v ? instr_of(tbl[c].pc) : 8'h00);
            chk($sformatf("c%0d imem_req", c), 8'(imem_req), 8'(tbl[c].req));
            if (tbl[c].req) chk($sformatf("c%0d imem_addr", c), imem_addr, tbl[c].addr);
            if (c >= 2 && c <= 5) begin
                e = 8'hFE + 8'(c - 2);
                chk($sformatf("c%0d wrap valid", c), 8'(valid_fe), 8'h01);
                chk($sformatf("c%0d wrap pc", c), pc_fe, e);
            end
            step();
        end
        chk("stream pops", 8'(sb_pops), 8'd8);

        // Redirect coincident with a response: response and pending pop discarded
        redirect_valid = 1'b1;
        redirect_pc = 8'h80;
        sb_reload(8'h80);
        #1;
        chk("rdr_rv imem_req", 8'(imem_req), 8'h00);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("rdr_rv if_valid", 8'(if_valid), 8'h00);
        chk("rdr_rv imem_req", 8'(imem_req), 8'h01);
        chk("rdr_rv imem_addr", imem_addr, 8'h80);
        repeat (8) step();
        chk("rdr_rv pops", 8'(sb_pops), 8'd6);

        // Redirect with request outstanding; late response dropped
        do_reset();
        mem_lat = 3;
        sb_reload(8'h00);
        reset = 1'b0;
        #1;
        chk("drop c0 imem_req", 8'(imem_req), 8'h01);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 8'h40;
        sb_reload(8'h40);
        #1;
        chk("drop c1 imem_req", 8'(imem_req), 8'h00);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("drop c2 imem_req", 8'(imem_req), 8'h00);
        step();
        chk("drop c3 imem_req", 8'(imem_req), 8'h01);
        chk("drop c3 imem_addr", imem_addr, 8'h40);
        chk("drop c3 if_valid", 8'(if_valid), 8'h00);
        step();
        wait_valid("drop wait", 20);
        chk("drop first pc", PC_IF, 8'h40);
        mem_lat = 1;
        repeat (8) step();
        chk("drop progress", 8'(sb_pops >= 4), 8'h01);

        // Reset mid-transaction, stale response in first cycle after release
        do_reset();
        stale_rv = 1'b1;
        stale_data = 8'hEE;
        sb_reload(8'h00);
        reset = 1'b0;
        #1;
        chk("stale imem_req", 8'(imem_req), 8'h01);
        chk("stale imem_addr", imem_addr, 8'h00);
        step();
        stale_rv = 1'b0;
        #1;
        chk("stale c1 if_valid", 8'(if_valid), 8'h00);
        step();
        chk("stale c2 if_valid", 8'(if_valid), 8'h01);
        chk("stale c2 pc", PC_IF, 8'h00);
        chk("stale c2 instr", Instruction_Code_IF, 8'h5A);
        repeat (3) step();

        // 8'hFF returned at PC 03
        do_reset();
        ff_at3 = 1'b1;
        sb_reload(8'h00);
        reset = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
        for (int c = 0; c < 12; c++) begin
            #1;
            chk($sformatf("h%0d halted", c), 8'(halted), (c >= 5) ? 8'h01 : 8'h00);
            chk($sformatf("h%0d imem_req", c), 8'(imem_req), (c >= 5) ? 8'h00 : 8'h01);
            step();
        end
        chk("halt pops", 8'(sb_pops), 8'd4);
        chk("halt drained", 8'(if_valid), 8'h00);
        ff_at3 = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 8'h10;
        sb_reload(8'h10);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("resume halted", 8'(halted), 8'h00);
        chk("resume imem_req", 8'(imem_req), 8'h01);
        chk("resume imem_addr", imem_addr, 8'h10);
        wait_valid("resume wait", 10);
        chk("resume pc", PC_IF, 8'h10);
        repeat (4) step();
`else
        for (int c = 0; c < 12; c++) begin
            #1;
            chk($sformatf("ff%0d halted", c), 8'(halted), 8'h00);
            step();
        end
        chk("ff pops", 8'(sb_pops), 8'd10);
        chk("ff imem_req", 8'(imem_req), 8'h01);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
